// File: rtl/reaction_pkg.sv
// reaction_pkg: shared FSM states, LFSR constants and width helper for reaction_arena
package reaction_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, GO, DONE, FAULT} state_t;

    // Galois taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// reaction_lfsr: free-running 16-bit Galois LFSR used to randomise the GO delay
module reaction_lfsr
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] value
);

    // shift right and fold the tap mask in whenever a one leaves the bottom
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) value <= SEED;
        else          value <= (value >> 1) ^ (value[0] ? LFSR_POLY : 16'h0000);

endmodule

// File: rtl/reaction_arena.sv
// reaction_arena: multi-player reaction timer (random delay, ms timing, winner, false starts)
// Optional best-time tracking is built when REACTION_BEST_TIME_EN is defined.
module reaction_arena
    import reaction_pkg::*;
#(
    parameter int          NUM_PLAYERS   = 2,
    parameter int          TICKS_PER_MS  = 50000,
    parameter int          TIME_W        = 14,
    parameter int          MIN_DELAY_MS  = 1000,
    parameter int          DELAY_SPAN_MS = 2048,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         WIN_W         = clog2_min1(NUM_PLAYERS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_btn,
    input  logic [NUM_PLAYERS-1:0] react_btn,
    output logic                   led,
    output logic                   busy,
    output logic                   result_valid,
    output logic [WIN_W-1:0]       winner,
    output logic [TIME_W-1:0]      winner_time,
    output logic                   timeout,
    output logic [NUM_PLAYERS-1:0] false_start,
    output logic [TIME_W-1:0]      best_time
);

    localparam int               PRE_W    = clog2_min1(TICKS_PER_MS);
    localparam int               DLY_W    = $clog2(MIN_DELAY_MS + DELAY_SPAN_MS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);
    localparam logic [TIME_W-1:0] MS_MAX  = '1;

    state_t             state, state_nx;
    logic               start_q;
    logic               start_rise;
    logic               tick;
    logic               any_press;
    logic               arm;
    logic               finish;
    logic [PRE_W-1:0]   presc;
    logic [DLY_W-1:0]   dly;
    logic [TIME_W-1:0]  ms;
    logic [15:0]        lfsr;
    logic [WIN_W-1:0]   first;

    reaction_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (lfsr)
    );

    assign start_rise = start_btn & ~start_q;
    assign tick       = presc == PRE_LAST;
    assign any_press  = |react_btn;
    assign arm        = state_nx == WAIT && state != WAIT;
    assign finish     = state == GO && state_nx == DONE;

    // lowest set react bit wins a same-cycle tie
    always_comb begin
        first = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--)
            if (react_btn[i]) first = WIN_W'(i);
    end

    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    // next state; a press in WAIT beats delay expiry in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        state_nx = start_rise ? WAIT : IDLE;
            WAIT:        state_nx = any_press ? FAULT : (tick && dly <= DLY_W'(1)) ? GO : WAIT;
            GO:          state_nx = (any_press || ms == MS_MAX) ? DONE : GO;
            DONE, FAULT: state_nx = start_rise ? WAIT : state;
            default:     state_nx = IDLE;
        endcase
    end

    // counters, registered status outputs and round results
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            start_q      <= 1'b0;
            presc        <= '0;
            dly          <= '0;
            ms           <= '0;
            led          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            winner       <= '0;
            winner_time  <= '0;
            false_start  <= '0;
        end else begin
            start_q      <= start_btn;
            led          <= state_nx == GO;
            busy         <= state_nx == WAIT || state_nx == GO;
            result_valid <= state_nx != state && (state_nx == DONE || state_nx == FAULT);
            presc        <= (state_nx != state || tick) ? '0 : presc + 1'b1;
            if (arm)
                dly <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr & 16'(DELAY_SPAN_MS - 1));
            else if (state == WAIT && tick)
                dly <= dly - 1'b1;
            if (state != GO)
                ms <= '0;
            else if (tick && ms != MS_MAX)
                ms <= ms + 1'b1;
            if (arm) begin
                winner      <= '0;
                winner_time <= '0;
                timeout     <= 1'b0;
                false_start <= '0;
            end
            if (state == WAIT && any_press)
                false_start <= react_btn;
            if (finish) begin
                winner      <= any_press ? first : '0;
                winner_time <= any_press ? ms : MS_MAX;
                timeout     <= !any_press;
            end
        end

`ifdef REACTION_BEST_TIME_EN
    // keep the fastest non-timeout result since reset
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            best_time <= '1;
        else if (finish && any_press && ms < best_time)
            best_time <= ms;
`else
    assign best_time = '1;
`endif

endmodule
